s298_resp_compactor: RTL and testbench

- Downstream response stage for the s298 benchmark core. It captures the core's six primary outputs on each valid beat and compacts them into a multiple-input signature register (MISR).
- After a programmed number of patterns, it compares the signature with a golden value and flags pass or fail.
- Used to check obfuscated and un-obfuscated bitstream builds of the same benchmark for functional equivalence on the FPGA.

---
 rtl/s298_resp_compactor.sv | 107 ++++++++++
 tb/tb_s298_resp_compactor.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/s298_resp_compactor.sv
// Response compactor for the s298 core: folds six-bit response beats into a MISR and compares with GOLDEN.
// Optional RESP_XMASK_EN adds a resp_mask input that zeroes selected response bits before compaction.
module s298_resp_compactor #(
  parameter int unsigned      SIG_W   = 16,
  parameter logic [SIG_W-1:0] POLY    = SIG_W'(16'h1021),
  parameter logic [SIG_W-1:0] SEED    = SIG_W'(16'hFFFF),
  parameter int unsigned      WARMUP  = 4,
  parameter int unsigned      NUM_PAT = 256,
  parameter logic [SIG_W-1:0] GOLDEN  = SIG_W'(16'h0000)
) (
  input  logic                            CK,
  input  logic                            RSTN,
  input  logic                            start,
  input  logic                            abort,
  input  logic                            resp_valid,
  input  logic [5:0]                      resp,
`ifdef RESP_XMASK_EN
  input  logic [5:0]                      resp_mask,
`endif
  output logic                            busy,
  output logic                            done,
  output logic                            pass,
  output logic [SIG_W-1:0]                signature,
  output logic [$clog2(NUM_PAT+1)-1:0]    pat_cnt
);

  localparam int unsigned CNT_W  = $clog2(NUM_PAT + 1);
  // Sized so the counter stays at least one bit wide even when WARMUP is 0.
  localparam int unsigned WARM_W = $clog2(WARMUP + 2);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WARM = 2'd1,
    ST_COMP = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t              state;
  logic [WARM_W-1:0]   warm_cnt;
  logic [WARM_W-1:0]   warm_inc;
  logic [CNT_W-1:0]    pat_inc;
  logic [5:0]          resp_eff;
  logic [SIG_W-1:0]    sig_next;

`ifdef RESP_XMASK_EN
  assign resp_eff = resp & ~resp_mask;
`else
  assign resp_eff = resp;
`endif

  // MISR step: shift drops the MSB, which selects the polynomial feedback.
  assign sig_next = {signature[SIG_W-2:0], 1'b0}
                  ^ (signature[SIG_W-1] ? POLY : '0)
                  ^ SIG_W'(resp_eff);

  assign warm_inc = warm_cnt + WARM_W'(1);
  assign pat_inc  = pat_cnt + CNT_W'(1);

  assign busy = (state == ST_WARM) || (state == ST_COMP);
  assign done = (state == ST_DONE);

  always_ff @(posedge CK or negedge RSTN) begin
    if (!RSTN) begin
      state     <= ST_IDLE;
      signature <= SEED;
      pat_cnt   <= '0;
      warm_cnt  <= '0;
      pass      <= 1'b0;
    end else if (abort) begin
      // Signature and count are left in place for post-mortem inspection.
      state <= ST_IDLE;
      pass  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            signature <= SEED;
            pat_cnt   <= '0;
            warm_cnt  <= '0;
            pass      <= 1'b0;
            state     <= (WARMUP == 0) ? ST_COMP : ST_WARM;
          end
        end
        ST_WARM: begin
          if (resp_valid) begin
            warm_cnt <= warm_inc;
            if (warm_inc == WARM_W'(WARMUP)) begin
              state <= ST_COMP;
            end
          end
        end
        ST_COMP: begin
          if (resp_valid) begin
            signature <= sig_next;
            pat_cnt   <= pat_inc;
            if (pat_inc == CNT_W'(NUM_PAT)) begin
              state <= ST_DONE;
              pass  <= (sig_next == GOLDEN);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_s298_resp_compactor.sv
// Directed bench for s298_resp_compactor: several parameterisations share one stimulus stream.
// Define RESP_XMASK_EN to also exercise the response mask.
module tb_s298_resp_compactor;

  logic        CK = 1'b0;
  logic        RSTN = 1'b1;
  logic        ck_en = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        resp_valid = 1'b0;
  logic [5:0]  resp = '0;
`ifdef RESP_XMASK_EN
  logic [5:0]  resp_mask = '0;
`endif

  int ncmp = 0;
  int nfail = 0;

  // u0: default parameters
  logic        b0, d0, p0;
  logic [15:0] s0;
  logic [8:0]  c0;
  // u1: SEED 8000, WARMUP 0, NUM_PAT 1, GOLDEN 1021
  logic        b1, d1, p1;
  logic [15:0] s1;
  logic [0:0]  c1;
  // u2: SEED 0, WARMUP 2, NUM_PAT 1, GOLDEN 003F
  logic        b2, d2, p2;
  logic [15:0] s2;
  logic [0:0]  c2;
  // u3: SEED 0001, WARMUP 0, NUM_PAT 3, GOLDEN 0
  logic        b3, d3, p3;
  logic [15:0] s3;
  logic [1:0]  c3;

  always begin
    #5;
    if (ck_en) CK = ~CK;
  end

  s298_resp_compactor u0 (
    .CK(CK), .RSTN(RSTN), .start(start), .abort(abort), .resp_valid(resp_valid), .resp(resp),
`ifdef RESP_XMASK_EN
    .resp_mask(resp_mask),
`endif
    .busy(b0), .done(d0), .pass(p0), .signature(s0), .pat_cnt(c0));

  s298_resp_compactor #(.SEED(16'h8000), .WARMUP(0), .NUM_PAT(1), .GOLDEN(16'h1021)) u1 (
    .CK(CK), .RSTN(RSTN), .start(start), .abort(abort), .resp_valid(resp_valid), .resp(resp),
`ifdef RESP_XMASK_EN
    .resp_mask(resp_mask),
`endif
    .busy(b1), .done(d1), .pass(p1), .signature(s1), .pat_cnt(c1));

  s298_resp_compactor #(.SEED(16'h0000), .WARMUP(2), .NUM_PAT(1), .GOLDEN(16'h003F)) u2 (
    .CK(CK), .RSTN(RSTN), .start(start), .abort(abort), .resp_valid(resp_valid), .resp(resp),
`ifdef RESP_XMASK_EN
    .resp_mask(resp_mask),
`endif
    .busy(b2), .done(d2), .pass(p2), .signature(s2), .pat_cnt(c2));

  s298_resp_compactor #(.SEED(16'h0001), .WARMUP(0), .NUM_PAT(3), .GOLDEN(16'h0000)) u3 (
    .CK(CK), .RSTN(RSTN), .start(start), .abort(abort), .resp_valid(resp_valid), .resp(resp),
`ifdef RESP_XMASK_EN
    .resp_mask(resp_mask),
`endif
    .busy(b3), .done(d3), .pass(p3), .signature(s3), .pat_cnt(c3));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  task automatic beat(input logic [5:0] r);
    resp_valid = 1'b1;
    resp = r;
    tick();
    resp_valid = 1'b0;
    resp = '0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_reset();
    RSTN = 1'b0;
    #3;
    RSTN = 1'b1;
    tick();
  endtask

  // Reference MISR step with the default polynomial, written from the definition.
  function automatic logic [15:0] misr(input logic [15:0] s, input logic [5:0] r);
    logic [15:0] t;
    t = s << 1;
    if (s[15]) t = t ^ 16'h1021;
    return t ^ {10'h000, r};
  endfunction

  logic [15:0] model;
  logic [15:0] held;

  initial begin
    // Reset with the clock stopped
    RSTN = 1'b0;
    #10;
    RSTN = 1'b1;
    #2;
    check("rst_sig", 32'(s0), 32'hFFFF);
    check("rst_cnt", 32'(c0), 32'd0);
    check("rst_busy", 32'(b0), 32'd0);
    check("rst_done", 32'(d0), 32'd0);
    check("rst_pass", 32'(p0), 32'd0);
    ck_en = 1'b1;

    // Single-beat run with polynomial feedback
    do_reset();
    do_start();
    check("u1_busy", 32'(b1), 32'd1);
    beat(6'h00);
    check("u1_sig", 32'(s1), 32'h1021);
    check("u1_done", 32'(d1), 32'd1);
    check("u1_pass", 32'(p1), 32'd1);
    check("u1_cnt", 32'(c1), 32'd1);

    // Warm-up beats are discarded
    do_reset();
    do_start();
    beat(6'h15);
    check("u2_warm1_sig", 32'(s2), 32'h0000);
    beat(6'h2A);
    check("u2_warm2_sig", 32'(s2), 32'h0000);
    check("u2_warm2_busy", 32'(b2), 32'd1);
    beat(6'h3F);
    check("u2_sig", 32'(s2), 32'h003F);
    check("u2_pass", 32'(p2), 32'd1);
    check("u2_done", 32'(d2), 32'd1);

    // Gapped beats, then a failing compare
    do_reset();
    do_start();
    beat(6'h00);
    check("u3_sig1", 32'(s3), 32'h0002);
    tick();
    tick();
    check("u3_gap_sig", 32'(s3), 32'h0002);
    beat(6'h00);
    check("u3_sig2", 32'(s3), 32'h0004);
    tick();
    check("u3_gap2_sig", 32'(s3), 32'h0004);
    beat(6'h00);
    check("u3_sig3", 32'(s3), 32'h0008);
    check("u3_done", 32'(d3), 32'd1);
    check("u3_pass", 32'(p3), 32'd0);
    // DONE ignores further beats and the count saturates
    beat(6'h3F);
    check("u3_done_hold_sig", 32'(s3), 32'h0008);
    check("u3_done_hold_cnt", 32'(c3), 32'd3);
    // Restart from DONE clears pass/done and reloads the seed
    check("u1_pre_restart_pass", 32'(p1), 32'd1);
    do_start();
    check("u1_restart_pass", 32'(p1), 32'd0);
    check("u1_restart_done", 32'(d1), 32'd0);
    check("u1_restart_sig", 32'(s1), 32'h8000);
    check("u3_restart_busy", 32'(b3), 32'd1);

    // Default parameters: 4 warm-up beats, 100 compacted beats, then abort
    do_reset();
    do_start();
    for (int i = 0; i < 4; i++) beat(6'h2A);
    check("u0_warm_sig", 32'(s0), 32'hFFFF);
    model = 16'hFFFF;
    for (int i = 0; i < 100; i++) begin
      beat(6'(i * 7 + 3));
      model = misr(model, 6'(i * 7 + 3));
    end
    check("u0_sig100", 32'(s0), 32'(model));
    check("u0_cnt100", 32'(c0), 32'd100);
    held = s0;
    // Start while busy is ignored
    do_start();
    check("u0_busy_start_cnt", 32'(c0), 32'd100);
    check("u0_busy_start_busy", 32'(b0), 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("u0_abort_busy", 32'(b0), 32'd0);
    check("u0_abort_done", 32'(d0), 32'd0);
    check("u0_abort_pass", 32'(p0), 32'd0);
    check("u0_abort_cnt", 32'(c0), 32'd100);
    check("u0_abort_sig", 32'(s0), 32'(held));
    // Abort beats a simultaneous start
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("u0_sa_busy", 32'(b0), 32'd0);
    check("u0_sa_done", 32'(d0), 32'd0);
    check("u0_sa_cnt", 32'(c0), 32'd100);

`ifdef RESP_XMASK_EN
    // Masked bits never reach the MISR (u2 with WARMUP 2 is not used here)
    do_reset();
    resp_mask = 6'h30;
    do_start();
    beat(6'h3F);
    check("u1_mask_sig", 32'(s1), 32'(misr(16'h8000, 6'h0F)));
    resp_mask = '0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
